fetch_unit: RTL and testbench

- Instruction fetch stage feeding the single-cycle control unit and datapath.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Presents the fetched instruction and its opcode to decode/control, then waits for the datapath's commit.
- On commit, updates the PC using the branch/zero/halt decision returned from control and the ALU.

---
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch_unit and imem.
// The master side issues requests, and the slave side returns ack and rdata.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over req/ack and waits for commit.
// Optional FETCH_PERF_CNT_EN adds saturating instr_count/stall_count outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    input  logic                commit,
    input  logic                branch,
    input  logic                zero,
    input  logic                halt,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         instr_count,
    output logic [31:0]         stall_count
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] branch_off;
    logic [31:0] branch_target;

    assign pc_plus4      = pc + 32'd4;
    assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_off;
    assign opcode        = instr[31:26];

    assign instr_valid    = (state == EXEC);
    assign halted         = (state == HALTED);
    // Gated by reset so no request leaves while the memory itself is held in reset.
    assign imem.imem_req  = (state == FETCH) && !reset;
    assign imem.imem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC_ALIGNED;
            instr <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr <= imem.imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            pc    <= (branch && zero) ? branch_target : pc_plus4;
                            state <= FETCH;
                        end
                    end
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if ((state == EXEC) && commit && !halt && (instr_count != '1))
                instr_count <= instr_count + 32'd1;
            if ((state == FETCH) && !imem.imem_ack && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: dut_a uses RESET_PC=0, and dut_b uses RESET_PC=0xFFFF_FFFC.
// Outputs are sampled on the falling edge, and inputs are changed there too.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        ack;
    logic [31:0] rdata;
    logic        commit, branch, zero, halt;

    logic [31:0] instr_a, pc_a, pc_plus4_a, instr_b, pc_b, pc_plus4_b;
    logic [5:0]  opcode_a, opcode_b;
    logic        valid_a, halted_a, valid_b, halted_b;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] icnt_a, scnt_a, icnt_b, scnt_b;
`endif

    int total = 0;
    int bad   = 0;

    fetch_unit_if ifa ();
    fetch_unit_if ifb ();
    assign ifa.imem_ack   = ack;
    assign ifa.imem_rdata = rdata;
    assign ifb.imem_ack   = ack;
    assign ifb.imem_rdata = rdata;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(rst_a), .imem(ifa),
        .instr(instr_a), .opcode(opcode_a), .instr_valid(valid_a),
        .pc(pc_a), .pc_plus4(pc_plus4_a),
        .commit(commit), .branch(branch), .zero(zero), .halt(halt),
        .halted(halted_a)
`ifdef FETCH_PERF_CNT_EN
        , .instr_count(icnt_a), .stall_count(scnt_a)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(rst_b), .imem(ifb),
        .instr(instr_b), .opcode(opcode_b), .instr_valid(valid_b),
        .pc(pc_b), .pc_plus4(pc_plus4_b),
        .commit(commit), .branch(branch), .zero(zero), .halt(halt),
        .halted(halted_b)
`ifdef FETCH_PERF_CNT_EN
        , .instr_count(icnt_b), .stall_count(scnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; ack = 1'b1; rdata = 32'h8C22_0004;
        commit = 1'b0; branch = 1'b0; zero = 1'b0; halt = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_req",    32'(ifa.imem_req), 32'd0);
        check("rst_valid",  32'(valid_a), 32'd0);
        check("rst_halted", 32'(halted_a), 32'd0);
        check("rst_pc",     pc_a, 32'h0);
        check("rst_instr",  instr_a, 32'h0);
        check("rst_b_pc",   pc_b, 32'hFFFF_FFFC);
        check("rst_b_req",  32'(ifb.imem_req), 32'd0);

        // Test 1: first fetch after reset, zero-wait memory
        rst_a = 1'b0;
        #1;
        check("t1_req",  32'(ifa.imem_req), 32'd1);
        check("t1_addr", ifa.imem_addr, 32'h0);
        tick();
        check("t1_valid",  32'(valid_a), 32'd1);
        check("t1_opcode", 32'(opcode_a), 32'd35);
        check("t1_pc4",    pc_plus4_a, 32'h4);
        check("t1_instr",  instr_a, 32'h8C22_0004);
        check("t1_req0",   32'(ifa.imem_req), 32'd0);

        // Test 2: sequential commits, so instr_valid is high exactly one cycle
        for (int k = 1; k <= 3; k++) begin
            commit = 1'b1;
            tick();
            check("t2_addr",   ifa.imem_addr, 32'(k * 4));
            check("t2_vlow",   32'(valid_a), 32'd0);
            check("t2_req",    32'(ifa.imem_req), 32'd1);
            commit = 1'b0;
            tick();
            check("t2_vhigh",  32'(valid_a), 32'd1);
            check("t2_pc",     pc_a, 32'(k * 4));
        end

        // Test 3: branch with negative offset at pc=0x10
        commit = 1'b1;
        tick();
        check("t3_addr10", ifa.imem_addr, 32'h10);
        commit = 1'b0; rdata = 32'h1000_FFFE;
        tick();
        check("t3_valid",  32'(valid_a), 32'd1);
        check("t3_opcode", 32'(opcode_a), 32'd4);
        check("t3_pc",     pc_a, 32'h10);
        branch = 1'bx; zero = 1'bx; halt = 1'bx;
        tick();
        check("t3_xhold_valid", 32'(valid_a), 32'd1);
        check("t3_xhold_pc",    pc_a, 32'h10);
        commit = 1'b1; branch = 1'b1; zero = 1'b1; halt = 1'b0;
        tick();
        check("t3_taken", ifa.imem_addr, 32'h0C);
        check("t3_taken_valid", 32'(valid_a), 32'd0);
        commit = 1'b0;
        tick();
        commit = 1'b1; branch = 1'b0; zero = 1'b0;
        tick();
        check("t3_back10", ifa.imem_addr, 32'h10);
        commit = 1'b0;
        tick();
        commit = 1'b1; branch = 1'b1; zero = 1'b0;
        tick();
        check("t3_nottaken", ifa.imem_addr, 32'h14);

        // Test 4: ack delayed three cycles
        commit = 1'b0; branch = 1'b0; ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("t4_req",   32'(ifa.imem_req), 32'd1);
            check("t4_addr",  ifa.imem_addr, 32'h14);
            check("t4_valid", 32'(valid_a), 32'd0);
            if (c < 3) tick();
        end
        ack = 1'b1;
        tick();
        check("t4_valid_after", 32'(valid_a), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("t4_stall_count", scnt_a, 32'd3);
        check("t4_instr_count", icnt_a, 32'd7);
`endif

        // Test 5: halt beats a taken branch, and only reset recovers
        commit = 1'b1; halt = 1'b1; branch = 1'b1; zero = 1'b1;
        tick();
        check("t5_halted", 32'(halted_a), 32'd1);
        check("t5_pc",     pc_a, 32'h14);
        check("t5_valid",  32'(valid_a), 32'd0);
        commit = 1'b0; halt = 1'b0; branch = 1'b0; zero = 1'b0;
        for (int c = 0; c < 22; c++) begin
            tick();
            check("t5_req_idle", 32'(ifa.imem_req), 32'd0);
            check("t5_stay_halted", 32'(halted_a), 32'd1);
        end
`ifdef FETCH_PERF_CNT_EN
        check("t5_instr_count", icnt_a, 32'd7);
`endif
        rst_a = 1'b1;
        tick();
        check("t5_rst_req",    32'(ifa.imem_req), 32'd0);
        check("t5_rst_halted", 32'(halted_a), 32'd0);
        rst_a = 1'b0;
        #1;
        check("t5_restart_req",  32'(ifa.imem_req), 32'd1);
        check("t5_restart_addr", ifa.imem_addr, 32'h0);

        // Test 6: wrap-around at the top of memory, then reset mid-fetch
        tick();
        rst_a = 1'b1; rdata = 32'h0000_0000; ack = 1'b1;
        rst_b = 1'b0;
        #1;
        check("t6_req",  32'(ifb.imem_req), 32'd1);
        check("t6_addr", ifb.imem_addr, 32'hFFFF_FFFC);
        check("t6_pc4",  pc_plus4_b, 32'h0);
        tick();
        check("t6_valid", 32'(valid_b), 32'd1);
        commit = 1'b1; branch = 1'b0;
        tick();
        check("t6_wrap", ifb.imem_addr, 32'h0);
        commit = 1'b0; ack = 1'b0;
        tick();
        check("t6_pending", ifb.imem_addr, 32'h0);
        rst_b = 1'b1;
        tick();
        check("t6_rst_addr",  ifb.imem_addr, 32'hFFFF_FFFC);
        check("t6_rst_valid", 32'(valid_b), 32'd0);
        check("t6_rst_instr", instr_b, 32'h0);
        rst_b = 1'b0;
        #1;
        check("t6_rst_req", 32'(ifb.imem_req), 32'd1);
        check("t6_halted_b", 32'(halted_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
